// File: rtl/cordic_pkg.sv
// Shared constants, state/quadrant encodings and pre-rotation helper for the cordic scheduler.
package cordic_pkg;

  localparam int ANGLE_W = 18;
  localparam int FRAC_W  = 16;
  localparam int SF      = 65536;
  localparam logic signed [ANGLE_W-1:0] HALF_PI = 18'sh19220;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;
  typedef enum logic [1:0] {QuadNone, QuadPos, QuadNeg} quad_e;

  typedef struct packed {
    logic signed [ANGLE_W-1:0] angle;
    quad_e                     quad;
  } prerot_t;

  // Fold angles beyond +-pi/2 back into the core's convergence range.
  // Done at ANGLE_W+1 bits; the folded result always fits back into ANGLE_W.
  function automatic prerot_t pre_rotate(input logic signed [ANGLE_W-1:0] a);
    logic signed [ANGLE_W:0] a_ext;
    logic signed [ANGLE_W:0] hp_ext;
    logic signed [ANGLE_W:0] sum;
    prerot_t r;
    a_ext  = {a[ANGLE_W-1], a};
    hp_ext = {HALF_PI[ANGLE_W-1], HALF_PI};
    if (a > HALF_PI) begin
      sum    = a_ext - hp_ext;
      r.quad = QuadPos;
    end else if (a < -HALF_PI) begin
      sum    = a_ext + hp_ext;
      r.quad = QuadNeg;
    end else begin
      sum    = a_ext;
      r.quad = QuadNone;
    end
    r.angle = sum[ANGLE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Scan from ptr upwards; the first hit wins and blocks later hits.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (enable && !any && req[j]) begin
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one iterative cordic core between NUM_REQ requesters: arbitrates, pre-rotates the
// angle, sequences the core's init/run phases, post-corrects cos/sin and tags the result.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ITERATIONS = 16,
  parameter int ID_W       = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ANGLE_W-1:0] req_angle,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic signed [ANGLE_W-1:0]  rsp_cos,
  output logic signed [ANGLE_W-1:0]  rsp_sin,
  output logic signed [ANGLE_W-1:0]  cordic_angle,
  output logic                       cordic_init,
  input  logic signed [ANGLE_W-1:0]  cordic_cos,
  input  logic signed [ANGLE_W-1:0]  cordic_sin,
  output logic                       busy
);

  localparam int CntW = $clog2(ITERATIONS + 1);

  state_e                    state_q, state_d;
  logic [ID_W-1:0]           ptr_q, ptr_d;
  logic [ID_W-1:0]           id_q, id_d;
  logic signed [ANGLE_W-1:0] angle_q, angle_d;
  quad_e                     quad_q, quad_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
  logic signed [ANGLE_W-1:0] rsp_cos_q, rsp_cos_d;
  logic signed [ANGLE_W-1:0] rsp_sin_q, rsp_sin_d;

  logic [NUM_REQ-1:0]        arb_grant;
  logic [ID_W-1:0]           arb_idx;
  logic                      arb_any;
  logic signed [ANGLE_W-1:0] grant_angle;
  prerot_t                   prerot;
  logic signed [ANGLE_W-1:0] corr_cos, corr_sin;

  // Arbitration only in IDLE; reset also masks it so req_ready reads 0 while reset is held.
  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .enable((state_q == StIdle) && !reset),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Select the granted requester's angle slice and fold it into range.
  always_comb begin
    grant_angle = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) grant_angle = req_angle[i*ANGLE_W +: ANGLE_W];
    end
    prerot = pre_rotate(grant_angle);
  end

  // Undo the pre-rotation on the core outputs (rotate back by +-pi/2).
  always_comb begin
    corr_cos = cordic_cos;
    corr_sin = cordic_sin;
    case (quad_q)
      QuadPos: begin
        corr_cos = -cordic_sin;
        corr_sin = cordic_cos;
      end
      QuadNeg: begin
        corr_cos = cordic_sin;
        corr_sin = -cordic_cos;
      end
      default: ;
    endcase
  end

  // Next-state and datapath updates for IDLE -> LOAD -> RUN -> DONE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    angle_d     = angle_q;
    quad_d      = quad_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_cos_d   = rsp_cos_q;
    rsp_sin_d   = rsp_sin_q;
    case (state_q)
      StIdle: begin
        if (arb_any) begin
          id_d    = arb_idx;
          angle_d = prerot.angle;
          quad_d  = prerot.quad;
          ptr_d   = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITERATIONS - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_cos_d   = corr_cos;
          rsp_sin_d   = corr_sin;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any job in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      angle_q     <= '0;
      quad_q      <= QuadNone;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_cos_q   <= '0;
      rsp_sin_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      angle_q     <= angle_d;
      quad_q      <= quad_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cos_q   <= rsp_cos_d;
      rsp_sin_q   <= rsp_sin_d;
    end
  end

  assign req_ready    = arb_grant;
  assign cordic_angle = angle_q;
  assign cordic_init  = (state_q != StRun);
  assign busy         = (state_q != StIdle);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_cos      = rsp_cos_q;
  assign rsp_sin      = rsp_sin_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler with a behavioural cordic core model.
module tb_cordic_scheduler;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [3:0]         req_valid = '0;
  logic [3:0]         req_ready;
  logic [71:0]        req_angle = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [1:0]         rsp_id;
  logic signed [17:0] rsp_cos, rsp_sin;
  logic signed [17:0] cordic_angle;
  logic               cordic_init;
  logic signed [17:0] cordic_cos, cordic_sin;
  logic               busy;

  int errors = 0;
  int checks = 0;

  cordic_scheduler #(
    .NUM_REQ   (4),
    .ITERATIONS(16),
    .ID_W      (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_angle   (req_angle),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_cos     (rsp_cos),
    .rsp_sin     (rsp_sin),
    .cordic_angle(cordic_angle),
    .cordic_init (cordic_init),
    .cordic_cos  (cordic_cos),
    .cordic_sin  (cordic_sin),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Core model: ideal cos/sin of the held angle while running, zero while parked.
  always_comb begin
    if (cordic_init) begin
      cordic_cos = '0;
      cordic_sin = '0;
    end else begin
      cordic_cos = 18'(int'($cos(real'(cordic_angle) / 65536.0) * 65536.0));
      cordic_sin = 18'(int'($sin(real'(cordic_angle) / 65536.0) * 65536.0));
    end
  end

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Issue one request and collect the response; no checking here.
  task automatic do_request(input int id, input logic [17:0] ang, output int lat,
                            output int initlow, output logic [1:0] rid,
                            output logic signed [17:0] c, output logic signed [17:0] s,
                            output bit tmo);
    bit seen;
    tmo = 1'b0; lat = 0; initlow = 0; rid = '0; c = '0; s = '0; seen = 1'b0;
    @(posedge clock); #1;
    req_angle[18*id +: 18] = ang;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clock);
      if (req_ready[id]) seen = 1'b1;
    end
    @(posedge clock); #1;
    req_valid[id] = 1'b0;
    if (!seen) begin
      tmo = 1'b1;
      return;
    end
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clock);
      lat++;
      if (!cordic_init) initlow++;
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) tmo = 1'b1;
    rid = rsp_id; c = rsp_cos; s = rsp_sin;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'b0001;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (cordic_init !== 1'b1) begin errors++; $display("FAIL rst_init: got %b want 1", cordic_init); end
    checks++; if (cordic_angle !== 18'sd0) begin errors++; $display("FAIL rst_angle: got %0d want 0", cordic_angle); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_cos !== 18'sd0 || rsp_sin !== 18'sd0) begin errors++; $display("FAIL rst_rsp_data: got %0d/%0d want 0/0", rsp_cos, rsp_sin); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    req_valid = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero();
    int lat, il; logic [1:0] rid; logic signed [17:0] c, s; bit tmo;
    do_request(0, 18'd0, lat, il, rid, c, s, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL zero_timeout: got timeout want response"); end
    checks++; if (rid !== 2'd0) begin errors++; $display("FAIL zero_id: got %0d want 0", rid); end
    checks++; if (absd(int'(c), 65536) > 16) begin errors++; $display("FAIL zero_cos: got %0d want 65536+-16", c); end
    checks++; if (absd(int'(s), 0) > 16) begin errors++; $display("FAIL zero_sin: got %0d want 0+-16", s); end
    checks++; if (lat != 18) begin errors++; $display("FAIL zero_latency: got %0d want 18", lat); end
  endtask

  task automatic test_first_quadrant();
    int lat, il; logic [1:0] rid; logic signed [17:0] c, s; bit tmo;
    do_request(1, 18'h14CCD, lat, il, rid, c, s, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL q1_timeout: got timeout want response"); end
    checks++; if (rid !== 2'd1) begin errors++; $display("FAIL q1_id: got %0d want 1", rid); end
    checks++; if (absd(int'(c), 17531) > 16) begin errors++; $display("FAIL q1_cos: got %0d want 17531+-16", c); end
    checks++; if (absd(int'(s), 63150) > 16) begin errors++; $display("FAIL q1_sin: got %0d want 63150+-16", s); end
    checks++; if (il != 16) begin errors++; $display("FAIL q1_init_low: got %0d want 16", il); end
  endtask

  task automatic test_quadrants();
    int lat, il; logic [1:0] rid; logic signed [17:0] c, s; bit tmo;
    do_request(3, 18'd124518, lat, il, rid, c, s, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL pos_timeout: got timeout want response"); end
    checks++; if (rid !== 2'd3) begin errors++; $display("FAIL pos_id: got %0d want 3", rid); end
    checks++; if (absd(int'(c), -21188) > 16) begin errors++; $display("FAIL pos_cos: got %0d want -21188+-16", c); end
    checks++; if (absd(int'(s), 62018) > 16) begin errors++; $display("FAIL pos_sin: got %0d want 62018+-16", s); end
    do_request(2, 18'(-85197), lat, il, rid, c, s, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL neg_timeout: got timeout want response"); end
    checks++; if (rid !== 2'd2) begin errors++; $display("FAIL neg_id: got %0d want 2", rid); end
    checks++; if (absd(int'(c), 17531) > 16) begin errors++; $display("FAIL neg_cos: got %0d want 17531+-16", c); end
    checks++; if (absd(int'(s), -63150) > 16) begin errors++; $display("FAIL neg_sin: got %0d want -63150+-16", s); end
    do_request(0, 18'(-124518), lat, il, rid, c, s, tmo);
    checks++; if (absd(int'(c), -21188) > 16 || absd(int'(s), -62018) > 16) begin
      errors++; $display("FAIL negq_result: got %0d/%0d want -21188/-62018 +-16", c, s);
    end
  endtask

  task automatic test_back_to_back();
    int order[4];
    int ng, twohot;
    bit idle;
    ng = 0; twohot = 0; idle = 1'b0;
    order = '{default: -1};
    reset = 1'b1;
    rsp_ready = 1'b1;
    req_angle = '0;
    req_valid = 4'b0101;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int n = 0; n < 200 && ng < 4; n++) begin
      @(negedge clock);
      if ($countones(req_ready) > 1) twohot++;
      if (req_ready != 4'b0000) begin
        for (int b = 0; b < 4; b++) if (req_ready[b]) order[ng] = b;
        ng++;
      end
    end
    @(posedge clock); #1;
    req_valid = '0;
    for (int n = 0; n < 60 && !idle; n++) begin
      @(negedge clock);
      if (!busy) idle = 1'b1;
    end
    checks++; if (ng != 4) begin errors++; $display("FAIL b2b_grants: got %0d want 4", ng); end
    checks++; if (order[0] != 0) begin errors++; $display("FAIL b2b_order0: got %0d want 0", order[0]); end
    checks++; if (order[1] != 2) begin errors++; $display("FAIL b2b_order1: got %0d want 2", order[1]); end
    checks++; if (order[2] != 0) begin errors++; $display("FAIL b2b_order2: got %0d want 0", order[2]); end
    checks++; if (order[3] != 2) begin errors++; $display("FAIL b2b_order3: got %0d want 2", order[3]); end
    checks++; if (twohot != 0) begin errors++; $display("FAIL b2b_twohot: got %0d want 0", twohot); end
    checks++; if (!idle) begin errors++; $display("FAIL b2b_drain: got busy want idle"); end
  endtask

  task automatic test_backpressure();
    int lat, il; logic [1:0] rid; logic signed [17:0] c, s; bit tmo, seen;
    rsp_ready = 1'b0;
    do_request(1, 18'h14CCD, lat, il, rid, c, s, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL bp_timeout: got timeout want response"); end
    req_angle[54 +: 18] = 18'd0;
    req_valid[3] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== rid || rsp_cos !== c || rsp_sin !== s) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b id=%0d %0d/%0d want v=1 id=%0d %0d/%0d",
                           n, rsp_valid, rsp_id, rsp_cos, rsp_sin, rid, c, s);
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy%0d: got %b want 1", n, busy); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d: got %b want 0000", n, req_ready); end
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hs_ready: got %b want 0000", req_ready); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_resume: got %b want 1000", req_ready); end
    @(posedge clock); #1;
    req_valid[3] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (!seen || rsp_id !== 2'd3) begin errors++; $display("FAIL bp_next: got seen=%b id=%0d want seen=1 id=3", seen, rsp_id); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_abort();
    int lat, il, spurious; logic [1:0] rid; logic signed [17:0] c, s; bit tmo, seen;
    seen = 1'b0; spurious = 0;
    @(posedge clock); #1;
    req_angle[36 +: 18] = 18'h14CCD;
    req_valid[2] = 1'b1;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clock);
      if (req_ready[2]) seen = 1'b1;
    end
    @(posedge clock); #1;
    req_valid[2] = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL abort_grant: got no grant want grant"); end
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clock);
      if (!cordic_init) seen = 1'b1;
    end
    repeat (7) @(negedge clock);
    req_valid[0] = 1'b1;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || cordic_init !== 1'b1 || cordic_angle !== 18'sd0) begin
      errors++; $display("FAIL abort_core: got busy=%b init=%b angle=%0d want 0/1/0", busy, cordic_init, cordic_angle);
    end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL abort_hs: got rsp_valid=%b req_ready=%b want 0/0000", rsp_valid, req_ready);
    end
    req_valid = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (rsp_valid) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL abort_no_rsp: got %0d want 0", spurious); end
    do_request(1, 18'd0, lat, il, rid, c, s, tmo);
    checks++; if (tmo || rid !== 2'd1) begin errors++; $display("FAIL abort_next_id: got tmo=%b id=%0d want 0/1", tmo, rid); end
    checks++; if (absd(int'(c), 65536) > 16 || absd(int'(s), 0) > 16) begin
      errors++; $display("FAIL abort_next_val: got %0d/%0d want 65536/0 +-16", c, s);
    end
    checks++; if (lat != 18) begin errors++; $display("FAIL abort_next_lat: got %0d want 18", lat); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_first_quadrant();
    test_quadrants();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
